mips_id_ex_stage: RTL and testbench
===================================

Name: mips_id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU in the pipelined MIPS core.
- Latches decoded operands and control from decode and builds the 32-bit immediate.
- Applies EX/MEM and MEM/WB forwarding and drives alu_op, first_data, second_data and shamt to the ALU.
- Detects load-use hazards, inserts bubbles, and honours downstream hold and branch flush.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-number width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  4  ALU opcode, in ALU encoding
- id_rs_data, id_rt_data  in  32  register-file read data
- id_rs, id_rt, id_rd  in  5  source and destination register numbers (id_rd already resolved rd/rt)
- id_imm  in  16  instruction immediate
- id_shamt  in  5  shift amount
- id_alu_src  in  1  1 = second_data takes the extended immediate
- id_sign_ext  in  1  1 = sign-extend imm, 0 = zero-extend
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- hold  in  1  downstream stall: freeze this stage
- flush  in  1  branch/jump squash of the decode slot
- exmem_reg_write  in  1,  exmem_rd  in  5,  exmem_result  in  32  EX/MEM forwarding source
- memwb_reg_write  in  1,  memwb_rd  in  5,  memwb_result  in  32  MEM/WB forwarding source
- alu_op  out  4  to ALU
- first_data  out  32  to ALU
- second_data  out  32  to ALU
- shamt  out  5  to ALU
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control
- ex_rd  out  5  registered destination register
- ex_store_data  out  32  forwarded rt value, for stores
- load_use_stall  out  1  tells IF/ID to hold this cycle

Behaviour:
- Register contents: valid, alu_op, rs/rt/rd, rs_data, rt_data, imm_ext, shamt, alu_src and the four control bits.
- Reset value of every register is 0, except alu_op, which resets to 4'b0011 (pass-through). Every output therefore reads 0 after reset, except alu_op = 4'b0011.
- Bubble: the reset value of all registers.
- Load-use hazard is combinational from registered and ID state. load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs | (ex_rd == id_rt & (!id_alu_src | id_mem_write))).
- Per-edge update priority:
  1. reset: clear to bubble.
  2. flush: bubble.
  3. hold: all registers keep their value.
  4. load_use_stall: bubble.
  5. otherwise: load the ID inputs. If id_valid = 0, the loaded controls are forced to 0.
- Immediate: imm_ext = id_sign_ext ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm}, computed at latch time.
- Forwarding (combinational, per source operand) fwd(r, d):
  - if exmem_reg_write & exmem_rd == r & r != 0, use exmem_result;
  - else if memwb_reg_write & memwb_rd == r & r != 0, use memwb_result;
  - else use d.
  - EX/MEM strictly beats MEM/WB.
  - Register 0 never forwards and always reads as its latched data.
- Outputs:
  - first_data = fwd(rs, rs_data).
  - ex_store_data = fwd(rt, rt_data).
  - second_data = alu_src ? imm_ext : ex_store_data.
  - alu_op and shamt come straight from their registers.
- Latency: an ID instruction appears at the ALU 1 cycle after the edge that accepts it. Forwarding adds no latency.
- Hold mid-hazard: load_use_stall keeps being evaluated while held, but no bubble is written until hold drops.
- Flush takes priority over load_use_stall: the squashed instruction is not replayed by this stage.
- Reset asserted mid-hold or mid-flush clears everything on that edge.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants (AND 0000, OR 0001, NOR 0010, PASS 0011, ADD 0100, ADDU 0101, SUB 0110, SUBU 0111, SLL 1000, SLA 1001, SRL 1010, SRA 1011, LUI 1100, SLT 1110, SLTU 1111);
  - the bubble alu_op constant (PASS);
  - DATA_W and REG_AW.
- One sub-module, mips_fwd_mux: the 3-way forwarding mux with its priority rule. It is instantiated twice (rs, rt).

Test Plan:
- Reset sequence: reset=1 for 2 cycles with arbitrary inputs -> ex_valid=0, alu_op=0011, first_data=0, second_data=0, load_use_stall=0.
- Immediate path: id_alu_src=1, imm=16'hFFF0, sign_ext=1 -> second_data=32'hFFFFFFF0. Same with sign_ext=0 -> 32'h0000FFF0.
- Double forward: latched rs=5; exmem (we=1, rd=5, 32'hAAAA0000) and memwb (we=1, rd=5, 32'h12345678) both match -> first_data=32'hAAAA0000. Drop exmem_reg_write -> first_data=32'h12345678.
- Register 0: rs=0 with exmem (we=1, rd=0, 32'hDEADBEEF) -> first_data equals the latched rs_data, not the forwarded value.
- Load-use: EX holds lw (mem_read=1, rd=8); ID is add with rs=8 -> load_use_stall=1; next edge ex_valid=0, alu_op=0011; the held add then loads on the following edge.
- Precedence: hold=1 for 3 cycles -> outputs unchanged. flush=1 together with hold=1 -> bubble next edge. flush=1 together with load_use_stall=1 -> bubble, no double insertion.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared datapath widths, ALU opcodes and ID/EX register layout
//               for the pipelined MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_NOR  = 4'b0010;
    localparam logic [3:0] c_ALU_PASS = 4'b0011;
    localparam logic [3:0] c_ALU_ADD  = 4'b0100;
    localparam logic [3:0] c_ALU_ADDU = 4'b0101;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SUBU = 4'b0111;
    localparam logic [3:0] c_ALU_SLL  = 4'b1000;
    localparam logic [3:0] c_ALU_SLA  = 4'b1001;
    localparam logic [3:0] c_ALU_SRL  = 4'b1010;
    localparam logic [3:0] c_ALU_SRA  = 4'b1011;
    localparam logic [3:0] c_ALU_LUI  = 4'b1100;
    localparam logic [3:0] c_ALU_SLT  = 4'b1110;
    localparam logic [3:0] c_ALU_SLTU = 4'b1111;

    localparam logic [3:0] c_BUBBLE_ALU_OP = c_ALU_PASS;

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm_ext;
        logic [REG_AW-1:0] shamt;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    // A bubble is all-zero except the ALU opcode, which is a harmless pass-through.
    localparam id_ex_t c_BUBBLE = '{
        valid:      1'b0,
        alu_op:     c_BUBBLE_ALU_OP,
        rs:         '0,
        rt:         '0,
        rd:         '0,
        rs_data:    '0,
        rt_data:    '0,
        imm_ext:    '0,
        shamt:      '0,
        alu_src:    1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0
    };

    function automatic logic [DATA_W-1:0] imm_extend(input logic [15:0] imm, input logic sign_ext);
        return sign_ext ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : mips_fwd_mux
// Description : Three-way operand forwarding mux; EX/MEM beats MEM/WB and
//               register 0 never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [DATA_W-1:0] src_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    logic w_src_nonzero;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_src_nonzero = (src_reg != '0);
    assign w_hit_exmem   = exmem_reg_write & (exmem_rd == src_reg) & w_src_nonzero;
    assign w_hit_memwb   = memwb_reg_write & (memwb_rd == src_reg) & w_src_nonzero;

    always_comb begin
        fwd_data = src_data;
        if (w_hit_exmem) begin
            fwd_data = exmem_result;
        end else if (w_hit_memwb) begin
            fwd_data = memwb_result;
        end
    end

endmodule : mips_fwd_mux
`default_nettype wire

// File: rtl/mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : mips_id_ex_stage
// Description : ID/EX pipeline register with immediate build, operand
//               forwarding, load-use bubble insertion, hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_shamt,
    input  logic              id_alu_src,
    input  logic              id_sign_ext,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              hold,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] first_data,
    output logic [DATA_W-1:0] second_data,
    output logic [REG_AW-1:0] shamt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_stall
);

    id_ex_t r_stage;
    id_ex_t w_load;
    logic   w_rt_hazard;

    // An rt match only stalls when rt is actually read: as ALU operand or as store data.
    assign w_rt_hazard    = (r_stage.rd == id_rt) & (~id_alu_src | id_mem_write);
    assign load_use_stall = r_stage.valid & r_stage.mem_read & id_valid & (r_stage.rd != '0)
                          & ((r_stage.rd == id_rs) | w_rt_hazard);

    always_comb begin
        w_load            = c_BUBBLE;
        w_load.valid      = id_valid;
        w_load.alu_op     = id_alu_op;
        w_load.rs         = id_rs;
        w_load.rt         = id_rt;
        w_load.rd         = id_rd;
        w_load.rs_data    = id_rs_data;
        w_load.rt_data    = id_rt_data;
        w_load.imm_ext    = imm_extend(id_imm, id_sign_ext);
        w_load.shamt      = id_shamt;
        w_load.alu_src    = id_alu_src;
        w_load.reg_write  = id_reg_write & id_valid;
        w_load.mem_read   = id_mem_read & id_valid;
        w_load.mem_write  = id_mem_write & id_valid;
        w_load.mem_to_reg = id_mem_to_reg & id_valid;
    end

    // Flush outranks hold; hold outranks the load-use bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stage <= c_BUBBLE;
        end else if (hold) begin
            r_stage <= r_stage;
        end else if (load_use_stall) begin
            r_stage <= c_BUBBLE;
        end else begin
            r_stage <= w_load;
        end
    end

    mips_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .src_reg         (r_stage.rs),
        .src_data        (r_stage.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (first_data)
    );

    mips_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .src_reg         (r_stage.rt),
        .src_data        (r_stage.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (ex_store_data)
    );

    assign second_data   = r_stage.alu_src ? r_stage.imm_ext : ex_store_data;
    assign alu_op        = r_stage.alu_op;
    assign shamt         = r_stage.shamt;
    assign ex_valid      = r_stage.valid;
    assign ex_reg_write  = r_stage.reg_write;
    assign ex_mem_read   = r_stage.mem_read;
    assign ex_mem_write  = r_stage.mem_write;
    assign ex_mem_to_reg = r_stage.mem_to_reg;
    assign ex_rd         = r_stage.rd;

endmodule : mips_id_ex_stage
`default_nettype wire

// File: tb/tb_mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_id_ex_stage
// Description : Directed scoreboard bench for the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_id_ex_stage;
    import mips_pkg::*;

    localparam int c_SEL_FIRST  = 0;
    localparam int c_SEL_SECOND = 1;
    localparam int c_SEL_ALUOP  = 2;
    localparam int c_SEL_VALID  = 3;
    localparam int c_SEL_STALL  = 4;
    localparam int c_SEL_RD     = 5;
    localparam int c_SEL_STORE  = 6;
    localparam int c_SEL_SHAMT  = 7;
    localparam int c_SEL_MEMRD  = 8;
    localparam int c_SEL_REGWR  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_alu_src, id_sign_ext;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        hold, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [3:0]  alu_op;
    logic [31:0] first_data, second_data;
    logic [4:0]  shamt;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic        load_use_stall;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mips_id_ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_alu_op       (id_alu_op),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_alu_src      (id_alu_src),
        .id_sign_ext     (id_sign_ext),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .hold            (hold),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .alu_op          (alu_op),
        .first_data      (first_data),
        .second_data     (second_data),
        .shamt           (shamt),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_rd           (ex_rd),
        .ex_store_data   (ex_store_data),
        .load_use_stall  (load_use_stall)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_SEL_FIRST:  return first_data;
            c_SEL_SECOND: return second_data;
            c_SEL_ALUOP:  return {28'd0, alu_op};
            c_SEL_VALID:  return {31'd0, ex_valid};
            c_SEL_STALL:  return {31'd0, load_use_stall};
            c_SEL_RD:     return {27'd0, ex_rd};
            c_SEL_STORE:  return ex_store_data;
            c_SEL_SHAMT:  return {27'd0, shamt};
            c_SEL_MEMRD:  return {31'd0, ex_mem_read};
            c_SEL_REGWR:  return {31'd0, ex_reg_write};
            default:      return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Clock edge, then sample 1 time unit later and drain the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Combinational-only check, no clock edge.
    task automatic settle();
        #1;
        drain();
    endtask

    task automatic id_clear();
        id_valid      = 1'b0; id_alu_op    = 4'd0;
        id_rs_data    = 32'd0; id_rt_data  = 32'd0;
        id_rs         = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_imm        = 16'd0; id_shamt = 5'd0;
        id_alu_src    = 1'b0; id_sign_ext = 1'b0;
        id_reg_write  = 1'b0; id_mem_read = 1'b0;
        id_mem_write  = 1'b0; id_mem_to_reg = 1'b0;
    endtask

    task automatic drive_lw();
        id_clear();
        id_valid = 1'b1; id_alu_op = c_ALU_ADD; id_rs = 5'd1; id_rs_data = 32'h100;
        id_rd = 5'd8; id_imm = 16'd4; id_sign_ext = 1'b1; id_alu_src = 1'b1;
        id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic drive_add_dep();
        id_clear();
        id_valid = 1'b1; id_alu_op = c_ALU_ADD; id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10;
        id_rs_data = 32'h80; id_rt_data = 32'h90; id_reg_write = 1'b1; id_shamt = 5'd3;
    endtask

    initial begin
        // Reset with busy inputs
        #2;
        id_clear();
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_alu_op = c_ALU_SUB; id_rs = 5'd3; id_rs_data = 32'h1234;
        id_rd = 5'd4; id_mem_read = 1'b1; id_shamt = 5'd7;
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hCAFE0001;
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hCAFE0002;
        step();
        push_exp("rst_valid", c_SEL_VALID, 32'd0);
        push_exp("rst_aluop", c_SEL_ALUOP, 32'h3);
        push_exp("rst_first", c_SEL_FIRST, 32'd0);
        push_exp("rst_second", c_SEL_SECOND, 32'd0);
        push_exp("rst_stall", c_SEL_STALL, 32'd0);
        push_exp("rst_shamt", c_SEL_SHAMT, 32'd0);
        push_exp("rst_store", c_SEL_STORE, 32'd0);
        step();

        // Immediate path
        reset = 1'b0;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        id_clear();
        id_valid = 1'b1; id_alu_op = c_ALU_ADD; id_rs = 5'd1; id_rs_data = 32'h11;
        id_rd = 5'd2; id_reg_write = 1'b1; id_alu_src = 1'b1; id_imm = 16'hFFF0; id_sign_ext = 1'b1;
        push_exp("imm_sext", c_SEL_SECOND, 32'hFFFFFFF0);
        push_exp("imm_first", c_SEL_FIRST, 32'h11);
        push_exp("imm_aluop", c_SEL_ALUOP, {28'd0, c_ALU_ADD});
        push_exp("imm_valid", c_SEL_VALID, 32'd1);
        push_exp("imm_rd", c_SEL_RD, 32'd2);
        step();
        id_sign_ext = 1'b0;
        push_exp("imm_zext", c_SEL_SECOND, 32'h0000FFF0);
        step();

        // Double forward on rs
        id_clear();
        id_valid = 1'b1; id_alu_op = c_ALU_OR; id_rs = 5'd5; id_rs_data = 32'h55;
        id_rt = 5'd6; id_rt_data = 32'h66; id_rd = 5'd7; id_reg_write = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA0000;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h12345678;
        push_exp("fwd_exmem_wins", c_SEL_FIRST, 32'hAAAA0000);
        push_exp("fwd_rt_nomatch", c_SEL_SECOND, 32'h66);
        step();
        exmem_reg_write = 1'b0;
        push_exp("fwd_memwb", c_SEL_FIRST, 32'h12345678);
        settle();
        memwb_rd = 5'd6;
        push_exp("fwd_rt_memwb", c_SEL_SECOND, 32'h12345678);
        push_exp("fwd_store_memwb", c_SEL_STORE, 32'h12345678);
        push_exp("fwd_rs_latched", c_SEL_FIRST, 32'h55);
        settle();

        // Register 0 never forwards
        id_rs = 5'd0; id_rs_data = 32'h0BADF00D;
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEADBEEF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0;
        push_exp("r0_nofwd", c_SEL_FIRST, 32'h0BADF00D);
        step();
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // Load-use: lw then dependent add
        drive_lw();
        push_exp("lw_memrd", c_SEL_MEMRD, 32'd1);
        push_exp("lw_second", c_SEL_SECOND, 32'd4);
        step();
        drive_add_dep();
        push_exp("lu_stall", c_SEL_STALL, 32'd1);
        settle();
        push_exp("lu_bubble_valid", c_SEL_VALID, 32'd0);
        push_exp("lu_bubble_aluop", c_SEL_ALUOP, 32'h3);
        push_exp("lu_stall_clear", c_SEL_STALL, 32'd0);
        step();
        push_exp("lu_add_valid", c_SEL_VALID, 32'd1);
        push_exp("lu_add_rd", c_SEL_RD, 32'd10);
        push_exp("lu_add_first", c_SEL_FIRST, 32'h80);
        push_exp("lu_add_second", c_SEL_SECOND, 32'h90);
        push_exp("lu_add_shamt", c_SEL_SHAMT, 32'd3);
        step();

        // Hold 3 cycles keeps everything
        hold = 1'b1;
        id_rs_data = 32'hFFFF; id_rd = 5'd20; id_alu_op = c_ALU_SLT;
        for (int i = 0; i < 3; i++) begin
            push_exp("hold_first", c_SEL_FIRST, 32'h80);
            push_exp("hold_rd", c_SEL_RD, 32'd10);
            push_exp("hold_aluop", c_SEL_ALUOP, {28'd0, c_ALU_ADD});
            step();
        end
        flush = 1'b1;
        push_exp("hold_flush_valid", c_SEL_VALID, 32'd0);
        push_exp("hold_flush_aluop", c_SEL_ALUOP, 32'h3);
        step();
        flush = 1'b0; hold = 1'b0;

        // Hold while a load-use hazard is pending
        drive_lw();
        step();
        drive_add_dep();
        hold = 1'b1;
        push_exp("hold_hz_memrd", c_SEL_MEMRD, 32'd1);
        push_exp("hold_hz_stall", c_SEL_STALL, 32'd1);
        step();
        hold = 1'b0;
        push_exp("hold_hz_bubble", c_SEL_VALID, 32'd0);
        step();

        // Flush with load-use pending: one bubble, then the ID slot loads
        drive_lw();
        step();
        drive_add_dep();
        flush = 1'b1;
        push_exp("fl_lu_stall", c_SEL_STALL, 32'd1);
        settle();
        push_exp("fl_lu_bubble", c_SEL_VALID, 32'd0);
        step();
        flush = 1'b0;
        push_exp("fl_lu_no_double", c_SEL_VALID, 32'd1);
        push_exp("fl_lu_rd", c_SEL_RD, 32'd10);
        step();

        // id_valid=0 forces control bits low
        id_valid = 1'b0; id_reg_write = 1'b1; id_mem_read = 1'b1;
        push_exp("inv_valid", c_SEL_VALID, 32'd0);
        push_exp("inv_memrd", c_SEL_MEMRD, 32'd0);
        push_exp("inv_regwr", c_SEL_REGWR, 32'd0);
        step();

        // Reset mid-hold clears
        drive_add_dep();
        step();
        hold = 1'b1; reset = 1'b1;
        push_exp("rst_hold_valid", c_SEL_VALID, 32'd0);
        push_exp("rst_hold_aluop", c_SEL_ALUOP, 32'h3);
        push_exp("rst_hold_first", c_SEL_FIRST, 32'd0);
        step();
        hold = 1'b0; reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mips_id_ex_stage
`default_nettype wire
